// File: rtl/i2c_omux_hold.sv
// i2c_omux_hold
// Open-drain SDA output stage. Selects one of NSRC serial data sources,
// registers the pull-low decision, holds that decision for a programmable
// number of clk cycles after every detected SCL falling edge, and reads the
// bus back on SCL rise to detect arbitration loss. After a loss, the driver
// stays locked off until the controller drops oe_in.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   oe_in           output enable from the controller
//   osel_in         source select (out-of-range selects release SDA)
//   sd_in           per-source data bits, 0 = pull SDA low
//   hold_cyc_in     SDA hold time in clk cycles after an SCL fall
//   scl_in, sda_in  asynchronous bus readback
//   sdaw_out        pad drive, only ever 0 or 'z
//   drv_low_out     1 while this block pulls SDA low
//   hold_busy_out   1 while the hold counter is nonzero
//   arb_lost_out    one-cycle pulse on arbitration loss
//   lockout_out     1 while the driver is locked off after a loss
module i2c_omux_hold #(
    parameter int NSRC        = 2,
    parameter int SELW        = $clog2(NSRC),
    parameter int HOLDW       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe_in,
    input  logic [SELW-1:0]  osel_in,
    input  logic [NSRC-1:0]  sd_in,
    input  logic [HOLDW-1:0] hold_cyc_in,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sdaw_out,
    output logic             drv_low_out,
    output logic             hold_busy_out,
    output logic             arb_lost_out,
    output logic             lockout_out
);

    localparam int NPAD = 1 << SELW;

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_q_reg;
    logic [HOLDW-1:0]       hold_cnt_reg;
    logic                   drv_low_reg;
    logic                   arb_lost_reg;
    logic                   lockout_reg;

    logic            scl_s;
    logic            sda_s;
    logic            fall;
    logic            rise;
    logic [NPAD-1:0] sd_pad;
    logic            sel_bit;
    logic            want_low;
    logic            arb_set;

    // Select vector padded up to a power of two; the padding reads as 1 so an
    // out-of-range select releases the line instead of indexing past sd_in.
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
        if (gi < NSRC) begin : g_src
            assign sd_pad[gi] = sd_in[gi];
        end else begin : g_rel
            assign sd_pad[gi] = 1'b1;
        end
    end

    assign scl_s    = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s    = sda_sync_reg[SYNC_STAGES-1];
    assign fall     = scl_q_reg & ~scl_s;
    assign rise     = ~scl_q_reg & scl_s;
    assign sel_bit  = sd_pad[osel_in];
    assign want_low = oe_in & ~sel_bit & ~lockout_reg;

    // We intended to release SDA (high) but the bus reads low at SCL rise:
    // another master is driving it. Only meaningful while enabled and not
    // already locked out.
    assign arb_set = rise & ~lockout_reg & oe_in & sel_bit & ~drv_low_reg & ~sda_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_q_reg    <= 1'b1;
            hold_cnt_reg <= '0;
            drv_low_reg  <= 1'b0;
            arb_lost_reg <= 1'b0;
            lockout_reg  <= 1'b0;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_q_reg    <= scl_s;

            // Every fall restarts the hold window, even mid-hold.
            if (fall) begin
                hold_cnt_reg <= hold_cyc_in;
            end else if (hold_cnt_reg != '0) begin
                hold_cnt_reg <= hold_cnt_reg - HOLDW'(1);
            end

            // Losing arbitration releases the line at once, overriding hold.
            if (arb_set) begin
                drv_low_reg <= 1'b0;
            end else if (hold_cnt_reg == '0 && !fall) begin
                drv_low_reg <= want_low;
            end

            arb_lost_reg <= arb_set;

            if (arb_set) begin
                lockout_reg <= 1'b1;
            end else if (!oe_in) begin
                lockout_reg <= 1'b0;
            end
        end
    end

    assign sdaw_out      = drv_low_reg ? 1'b0 : 1'bz;
    assign drv_low_out   = drv_low_reg;
    assign hold_busy_out = (hold_cnt_reg != '0);
    assign arb_lost_out  = arb_lost_reg;
    assign lockout_out   = lockout_reg;

endmodule
